// File: rtl/interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// interrupt_arbiter
//   Claim/complete interrupt sequencer between level-sensitive interrupt
//   sources and the CPU.
//
//   The block latches requests into pending bits. It picks one winner among
//   the sources that are both pending and enabled, using round-robin order
//   that starts after the last claimed ID. It raises irq_o until the CPU
//   claims the winner. It then blocks that source until the CPU writes a
//   matching completion.
//
// Ports
//   clk_i          in   1   system clock
//   reset_ni       in   1   synchronous reset, active low
//   source_i       in   32  level interrupt requests (bits >= NUM_SOURCES unused)
//   irq_o          out  1   registered interrupt request to the CPU
//   chip_select_i  in   1   bus: block selected
//   addr_i         in   4   bus: register port
//   read_enable_i  in   1   bus: read strobe
//   read_data_o    out  32  bus: registered read data (holds when no read)
//   write_data_i   in   32  bus: write data
//   write_mask_i   in   4   bus: byte write enables
//
// Register ports
//   0 PENDING  RO    1 ENABLED  RW (byte masked)    2 CLAIM  RO (side effect)
//   3 COMPLETE WO    4 STATUS   RO {state, 25'b0, cur_id}
// ---------------------------------------------------------------------------
module interrupt_arbiter #(
    parameter int NUM_SOURCES = 32
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] source_i,
    output logic        irq_o,
    input  logic        chip_select_i,
    input  logic [3:0]  addr_i,
    input  logic        read_enable_i,
    output logic [31:0] read_data_o,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_mask_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NOTIFY  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Only the low NUM_SOURCES bits of pending/enabled ever hold a 1.
    localparam logic [31:0] SRC_MASK   = 32'hFFFF_FFFF >> (32 - NUM_SOURCES);
    localparam logic [4:0]  LAST_RESET = 5'(NUM_SOURCES - 1);

    localparam logic [3:0] ADDR_PENDING  = 4'd0;
    localparam logic [3:0] ADDR_ENABLED  = 4'd1;
    localparam logic [3:0] ADDR_CLAIM    = 4'd2;
    localparam logic [3:0] ADDR_COMPLETE = 4'd3;
    localparam logic [3:0] ADDR_STATUS   = 4'd4;

    state_t      state_reg, state_next;
    logic [31:0] pending_reg, pending_next;
    logic [31:0] enabled_reg, enabled_next;
    logic [4:0]  cur_id_reg, cur_id_next;
    logic [4:0]  last_id_reg, last_id_next;
    logic [31:0] read_data_next;
    logic        irq_next;

    logic        rd_access;
    logic        wr_access;
    logic        claim_read;
    logic        complete_write;
    logic        claim;
    logic [31:0] active;
    logic        cur_active;
    logic [4:0]  winner;
    logic        winner_found;
    logic [5:0]  scan_idx;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign rd_access      = chip_select_i & read_enable_i;
    assign wr_access      = chip_select_i & (|write_mask_i);
    assign claim_read     = rd_access & (addr_i == ADDR_CLAIM);
    assign complete_write = wr_access & (addr_i == ADDR_COMPLETE) & write_mask_i[0];

    assign active     = pending_reg & enabled_reg;
    assign cur_active = active[cur_id_reg];

    // ------------------------------------------------------------------
    // Round-robin search: the first active ID after last_id_reg, wrapping
    // modulo NUM_SOURCES. A 6-bit index holds last_id + offset (at most 63)
    // without overflow before the wrap.
    // ------------------------------------------------------------------
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        scan_idx     = '0;
        for (int off = 1; off <= NUM_SOURCES; off++) begin
            scan_idx = {1'b0, last_id_reg} + 6'(off);
            if (scan_idx >= 6'(NUM_SOURCES)) begin
                scan_idx = scan_idx - 6'(NUM_SOURCES);
            end
            if (!winner_found && active[scan_idx[4:0]]) begin
                winner_found = 1'b1;
                winner       = scan_idx[4:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and claim decision
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cur_id_next  = cur_id_reg;
        last_id_next = last_id_reg;
        claim        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|active) begin
                    cur_id_next = winner;
                    state_next  = ST_NOTIFY;
                end
            end
            ST_NOTIFY: begin
                // A source disabled while waiting for its claim is withdrawn.
                // A claim read in that same cycle sees nothing to claim.
                if (!cur_active) begin
                    state_next = ST_IDLE;
                end else if (claim_read) begin
                    claim        = 1'b1;
                    last_id_next = cur_id_reg;
                    state_next   = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (complete_write && (write_data_i[4:0] == cur_id_reg)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // irq_o is registered, so it follows the state being entered.
    assign irq_next = (state_next == ST_NOTIFY);

    // ------------------------------------------------------------------
    // Pending gateway. The source under service cannot re-pend itself.
    // A claim clears the bit even if the source is still high.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            if (gi < NUM_SOURCES) begin : g_used
                logic is_cur;
                assign is_cur = (cur_id_reg == 5'(gi));
                assign pending_next[gi] =
                    (claim && is_cur) ? 1'b0 :
                    (pending_reg[gi] |
                     (source_i[gi] & ~((state_reg == ST_SERVICE) & is_cur)));
            end else begin : g_unused
                assign pending_next[gi] = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Enable register with byte-masked writes
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_enable_byte
            assign enabled_next[gi*8 +: 8] =
                (wr_access && (addr_i == ADDR_ENABLED) && write_mask_i[gi]) ?
                (write_data_i[gi*8 +: 8] & SRC_MASK[gi*8 +: 8]) :
                enabled_reg[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read data: returns register values from before the edge. Holds when
    // there is no read.
    // ------------------------------------------------------------------
    always_comb begin
        read_data_next = read_data_o;
        if (rd_access) begin
            case (addr_i)
                ADDR_PENDING: read_data_next = pending_reg;
                ADDR_ENABLED: read_data_next = enabled_reg;
                ADDR_CLAIM:   read_data_next = claim ? {1'b1, 26'b0, cur_id_reg} : 32'h0;
                ADDR_STATUS:  read_data_next = {state_reg, 25'b0, cur_id_reg};
                default:      read_data_next = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset takes priority over any bus access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
            enabled_reg <= '0;
            cur_id_reg  <= '0;
            last_id_reg <= LAST_RESET;
            read_data_o <= '0;
            irq_o       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            enabled_reg <= enabled_next;
            cur_id_reg  <= cur_id_next;
            last_id_reg <= last_id_next;
            read_data_o <= read_data_next;
            irq_o       <= irq_next;
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_interrupt_arbiter
//   Directed bench for interrupt_arbiter with hand-computed expected values.
//   Inputs change 1 ns after the rising edge. Outputs are sampled at the
//   same point.
// ---------------------------------------------------------------------------
module tb_interrupt_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] source;
    logic        irq;
    logic        cs;
    logic [3:0]  addr;
    logic        re;
    logic [31:0] read_data;
    logic [31:0] wdata;
    logic [3:0]  wmask;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    interrupt_arbiter #(.NUM_SOURCES(32)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .source_i      (source),
        .irq_o         (irq),
        .chip_select_i (cs),
        .addr_i        (addr),
        .read_enable_i (re),
        .read_data_o   (read_data),
        .write_data_i  (wdata),
        .write_mask_i  (wmask)
    );

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        cs   = 1'b1;
        re   = 1'b1;
        addr = a;
        tick();
        cs = 1'b0;
        re = 1'b0;
        d  = read_data;
        $display("[TB] RD addr=%0d data=0x%08h irq=%0b", a, d, irq);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        cs    = 1'b1;
        addr  = a;
        wdata = d;
        wmask = m;
        tick();
        cs    = 1'b0;
        wmask = 4'h0;
        $display("[TB] WR addr=%0d data=0x%08h mask=0x%0h irq=%0b", a, d, m, irq);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        source  = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Bounded wait for irq; an expired budget counts as a failed comparison.
    task automatic wait_irq(input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_value(tag, {31'b0, irq}, 32'h1);
    endtask

    logic [31:0] d;
    logic [4:0]  exp_ids [4];

    initial begin
        reset_n = 1'b0;
        source  = '0;
        cs      = 1'b0;
        addr    = '0;
        re      = 1'b0;
        wdata   = '0;
        wmask   = '0;
        exp_ids = '{5'd3, 5'd7, 5'd3, 5'd7};

        // ---- 1: basic notify / claim / complete on source 0 ----
        tick();
        tick();
        check_value("rst_irq", {31'b0, irq}, 32'h0);
        check_value("rst_rdata", read_data, 32'h0);
        reset_n = 1'b1;
        bus_read(4'd0, d); check_value("t1_pending0", d, 32'h0);
        bus_read(4'd4, d); check_value("t1_status0", d, 32'h0);
        bus_write(4'd1, 32'h1, 4'hF);
        source = 32'h1;
        tick();                      // pending latched at this edge
        source = 32'h0;
        check_value("t1_irq_k", {31'b0, irq}, 32'h0);
        tick();                      // NOTIFY entered, irq registered high
        check_value("t1_irq_k1", {31'b0, irq}, 32'h1);
        bus_read(4'd2, d); check_value("t1_claim", d, 32'h8000_0000);
        check_value("t1_irq_drop", {31'b0, irq}, 32'h0);
        bus_read(4'd4, d); check_value("t1_status_svc", d, 32'h8000_0000);
        bus_write(4'd3, 32'h0, 4'h1);
        bus_read(4'd4, d); check_value("t1_status_idle", d, 32'h0);
        bus_read(4'd0, d); check_value("t1_pending_clr", d, 32'h0);

        // ---- 2: round-robin between sources 3 and 7 ----
        do_reset();
        source = 32'h88;
        bus_write(4'd1, 32'h88, 4'hF);
        for (int i = 0; i < 4; i++) begin
            wait_irq($sformatf("t2_irq%0d", i));
            bus_read(4'd2, d);
            check_value($sformatf("t2_claim%0d", i), d, {1'b1, 26'b0, exp_ids[i]});
            bus_write(4'd3, {27'b0, exp_ids[i]}, 4'h1);
        end

        // ---- 3: mismatched / unmasked completes ignored, then re-assert ----
        do_reset();
        source = 32'h20;
        bus_write(4'd1, 32'h20, 4'hF);
        wait_irq("t3_irq");
        bus_read(4'd2, d); check_value("t3_claim", d, 32'h8000_0005);
        bus_write(4'd3, 32'h4, 4'h1);
        bus_read(4'd4, d); check_value("t3_status_wrongid", d, 32'h8000_0005);
        check_value("t3_irq_svc", {31'b0, irq}, 32'h0);
        bus_write(4'd3, 32'h5, 4'h2);
        bus_read(4'd4, d); check_value("t3_status_nomask", d, 32'h8000_0005);
        bus_write(4'd3, 32'h5, 4'h1);
        bus_read(4'd4, d); check_value("t3_status_done", d, 32'h0000_0005);
        wait_irq("t3_reassert");

        // ---- 4: disable while in NOTIFY withdraws the request ----
        do_reset();
        bus_write(4'd1, 32'h4, 4'hF);
        source = 32'h4;
        tick();
        source = 32'h0;
        wait_irq("t4_irq");
        bus_write(4'd1, 32'h0, 4'hF);
        tick();
        check_value("t4_irq_off", {31'b0, irq}, 32'h0);
        bus_read(4'd4, d); check_value("t4_status", d, 32'h0000_0002);
        bus_read(4'd0, d); check_value("t4_pending", d, 32'h4);

        // ---- 5: claim in IDLE, read hold, unmapped read, byte-masked enable ----
        bus_read(4'd2, d); check_value("t5_claim_idle", d, 32'h0);
        bus_read(4'd0, d); check_value("t5_pending", d, 32'h4);
        tick();
        check_value("t5_rdata_hold", read_data, 32'h4);
        bus_read(4'd9, d); check_value("t5_unmapped", d, 32'h0);
        bus_write(4'd1, 32'hFFFF_FFFF, 4'b0100);
        bus_read(4'd1, d); check_value("t5_enable_byte2", d, 32'h00FF_0000);

        // ---- 6: reset mid-SERVICE together with a COMPLETE write ----
        do_reset();
        bus_write(4'd1, 32'h2, 4'hF);
        source = 32'h2;
        tick();
        source = 32'h0;
        wait_irq("t6_irq");
        bus_read(4'd2, d); check_value("t6_claim", d, 32'h8000_0001);
        reset_n = 1'b0;
        cs      = 1'b1;
        addr    = 4'd3;
        wdata   = 32'h1;
        wmask   = 4'h1;
        tick();
        cs      = 1'b0;
        wmask   = 4'h0;
        reset_n = 1'b1;
        $display("[TB] RST+WR addr=3 data=0x00000001 irq=%0b", irq);
        check_value("t6_irq", {31'b0, irq}, 32'h0);
        check_value("t6_rdata", read_data, 32'h0);
        bus_read(4'd0, d); check_value("t6_pending", d, 32'h0);
        bus_read(4'd1, d); check_value("t6_enabled", d, 32'h0);
        bus_read(4'd4, d); check_value("t6_status", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
